acc_stack: RTL
==============

# acc_stack

Parametrised accumulator for the RISC core: a WIDTH-bit ACC register that captures the ALU result, plus a DEPTH-entry LIFO for saving and restoring ACC across subroutine and interrupt entry. The timing controller drives load/push/pop strobes. ACC feeds back into the ALU and onto the data bus. Stack occupancy, status and sticky error flags go back to the controller.

## Interface
- WIDTH, 8, data width of ACC and of each stack entry
- DEPTH, 4, number of stack entries (legal range 2..16)
- RST_VAL, 0, reset value of ACC
- clk  input  1  RISC core clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ld_acc  input  1  load out_alu into ACC
- push_acc  input  1  push current ACC onto stack
- pop_acc  input  1  pop top of stack into ACC
- clr_err  input  1  synchronous clear of sticky error flags
- out_alu  input  WIDTH  ALU result
- out_acc  output  WIDTH  ACC value
- acc_zero  output  1  out_acc == 0
- stk_cnt  output  5  entries currently held, 0..DEPTH
- stk_empty  output  1  stk_cnt == 0
- stk_full  output  1  stk_cnt == DEPTH
- stk_ovf  output  1  sticky, push attempted while full
- stk_unf  output  1  sticky, pop (or swap) attempted while empty
- swap_acc  input  1  exchange ACC with top of stack; present only with ACC_SWAP_EN

## Operation
- Reset values: out_acc = RST_VAL, stk_cnt = 0, stk_empty = 1, stk_full = 0, stk_ovf = 0, stk_unf = 0, acc_zero = (RST_VAL == 0). Stack entry contents are don't-care.
- Each cycle's operation is decided from the strobes sampled at the rising edge, in the following priority.
- push_acc and pop_acc together: the stack is unchanged and no error is flagged. ld_acc still applies.
- pop_acc alone, not empty: ACC <= top, stk_cnt - 1. ld_acc is ignored.
- pop_acc alone, empty: the pop is ignored and stk_unf is set. ld_acc applies if asserted.
- push_acc alone, not full: the stack receives the pre-edge ACC, stk_cnt + 1. If ld_acc is also asserted, ACC <= out_alu in the same edge (save-then-load).
- push_acc alone, full: the stack and stk_cnt are unchanged and stk_ovf is set. ld_acc still applies.
- ld_acc only: ACC <= out_alu.
- No strobe: all state holds.
- Stack organisation: entry array plus write pointer equal to stk_cnt. No wrap-around: overflow never overwrites the oldest entry.
- Sticky flags: clr_err clears them. A new error in the same cycle as clr_err wins, so the flag reads 1.
- Widths: no arithmetic on data. stk_cnt is a 5-bit counter and saturates at the bounds because the full/empty checks above block further change.

## Timing
- All outputs are registered state or combinational decode of registered state. There is no combinational path from inputs to outputs.
- Latency is 1 cycle: a strobe sampled at edge N is reflected on out_acc, stk_cnt and the flags right after edge N.
- Back-to-back push/pop/ld on consecutive cycles is supported at full rate with no bubbles.
- Reset asserted mid-operation immediately forces the reset values. Stack contents are lost.
- Strobes are level-sampled, one operation per asserted cycle. Holding push_acc for 3 cycles performs 3 pushes.

## Configuration
- Macro ACC_SWAP_EN.
- Defined:
  - The swap_acc port exists and has highest priority. Swap with any other strobe: only the swap executes.
  - Not empty: ACC <= top and top <= pre-edge ACC. stk_cnt is unchanged.
  - Empty: no change and stk_unf is set.
- Undefined: the swap_acc port is absent and the behaviour is exactly as in Operation.

## Test plan
- Reset, then ld_acc with out_alu = 8'h5A: out_acc = 8'h5A, acc_zero = 0, stk_empty = 1. Assert rst_n low mid-cycle: out_acc = 8'h00 immediately.
- Load 8'h11, 8'h22, 8'h33, 8'h44, pushing after each load, then one more push: stk_full = 1, stk_cnt = 4, stk_ovf = 1. Four pops then return ACC = 8'h44, 8'h33, 8'h22, 8'h11.
- From empty, pop with ld_acc and out_alu = 8'h7E: ACC = 8'h7E and stk_unf = 1. A clr_err pulse clears it. clr_err together with another empty pop leaves stk_unf = 1.
- ACC = 8'h10, push + ld_acc with out_alu = 8'h20: ACC = 8'h20, stk_cnt = 1. A following pop gives ACC = 8'h10.
- push + pop together with stk_cnt = 2: stk_cnt stays 2 and no flags are set. Adding ld_acc with out_alu = 8'h00 gives ACC = 8'h00 and acc_zero = 1.
- ACC_SWAP_EN defined, ACC = 8'hAA, top = 8'h55: swap gives ACC = 8'h55, then a pop gives ACC = 8'hAA. Swap on an empty stack sets stk_unf.

Source files
------------

// File: rtl/acc_stack.sv
// acc_stack: WIDTH-bit accumulator with a DEPTH-entry LIFO used to save and
// restore ACC around subroutine/interrupt entry. Sticky overflow/underflow
// flags report stack misuse back to the timing controller.
// Optional feature: define ACC_SWAP_EN to add the swap_acc strobe, which
// exchanges ACC with the top of stack and outranks every other strobe.
module acc_stack #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_acc,
  input  logic             push_acc,
  input  logic             pop_acc,
  input  logic             clr_err,
`ifdef ACC_SWAP_EN
  input  logic             swap_acc,
`endif
  input  logic [WIDTH-1:0] out_alu,
  output logic [WIDTH-1:0] out_acc,
  output logic             acc_zero,
  output logic [4:0]       stk_cnt,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_ovf,
  output logic             stk_unf
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             unf, unf_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    top_idx;
  logic             swap_req;

`ifdef ACC_SWAP_EN
  assign swap_req = swap_acc;
`else
  assign swap_req = 1'b0;
`endif

  // Top of stack sits one below the write pointer; only used when not empty.
  assign top_idx   = AW'(cnt - 5'd1);

  assign out_acc   = acc;
  assign acc_zero  = (acc == '0);
  assign stk_cnt   = cnt;
  assign stk_empty = (cnt == 5'd0);
  assign stk_full  = (cnt == DEPTH_CNT);
  assign stk_ovf   = ovf;
  assign stk_unf   = unf;

  // Decode the strobes by priority into next ACC, pointer, flags and stack write.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    ovf_nxt = clr_err ? 1'b0 : ovf;
    unf_nxt = clr_err ? 1'b0 : unf;
    wr_en   = 1'b0;
    wr_idx  = AW'(cnt);
    wr_data = acc;

    if (swap_req) begin
      if (!stk_empty) begin
        acc_nxt = mem[top_idx];
        wr_en   = 1'b1;
        wr_idx  = top_idx;
      end else begin
        unf_nxt = 1'b1;
      end
    end else if (push_acc && pop_acc) begin
      // Simultaneous push and pop cancel out; the load still goes through.
      if (ld_acc) acc_nxt = out_alu;
    end else if (pop_acc) begin
      if (!stk_empty) begin
        acc_nxt = mem[top_idx];
        cnt_nxt = cnt - 5'd1;
      end else begin
        unf_nxt = 1'b1;
        if (ld_acc) acc_nxt = out_alu;
      end
    end else if (push_acc) begin
      // The stack captures the pre-edge ACC, so push+load is save-then-load.
      if (!stk_full) begin
        wr_en   = 1'b1;
        cnt_nxt = cnt + 5'd1;
      end else begin
        ovf_nxt = 1'b1;
      end
      if (ld_acc) acc_nxt = out_alu;
    end else if (ld_acc) begin
      acc_nxt = out_alu;
    end
  end

  // Control state: ACC, occupancy and sticky flags, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= RST_VAL;
      cnt <= 5'd0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end

  // Stack entries carry no reset; contents are meaningless once cnt drops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule
